sdram_write: RTL

- SDRAM write-path engine; the counterpart of the SDRAM read engine on the same command/address bus.
- Requests bus ownership from the arbiter, then issues ACTIVE, WRITE bursts of 4 and PRECHARGE.
- Pulls write data from an upstream FWFT FIFO.
- Walks the address space linearly: column, then row, with wrap.

---
 rtl/sdram_write_if.sv | 35 +++
 rtl/sdram_write.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/sdram_write_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | sdram_write_if                                                        |
// | Arbiter handshake, SDRAM command/address/DQ and FIFO signals of the   |
// | SDRAM write engine.                                                   |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
interface sdram_write_if;
  logic        write_trig;
  logic        refresh_req;
  logic        arbit_write_req;
  logic        arbit_write_ack;
  logic        arbit_write_end;
  logic        arbit_prech_end;
  logic [3:0]  cmd_reg;
  logic [12:0] sdram_addr;
  logic [1:0]  sdram_bank_addr;
  logic        wr_data_req;
  logic [15:0] wr_data;
  logic [15:0] sdram_dq;
  logic        sdram_dq_oe;

  modport master (
    input  write_trig, refresh_req, arbit_write_ack, wr_data,
    output arbit_write_req, arbit_write_end, arbit_prech_end, cmd_reg,
           sdram_addr, sdram_bank_addr, wr_data_req, sdram_dq, sdram_dq_oe
  );

  modport slave (
    output write_trig, refresh_req, arbit_write_ack, wr_data,
    input  arbit_write_req, arbit_write_end, arbit_prech_end, cmd_reg,
           sdram_addr, sdram_bank_addr, wr_data_req, sdram_dq, sdram_dq_oe
  );
endinterface
`default_nettype wire

// File: rtl/sdram_write.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | sdram_write                                                           |
// | SDRAM write engine: ACTIVE / WRITE x4 bursts / PRECHARGE, linear      |
// | column-then-row walk. Option macro: WRITE_PINGPONG_EN (bank toggle).  |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module sdram_write #(
  parameter int BURST_TIMES  = 64,
  parameter int ROW_ADDR_END = 938,
  parameter int COL_ADDR_END = 256,
  parameter int BANK         = 0
) (
  input  wire logic     sysclk_100M,
  input  wire logic     rst_n,
  sdram_write_if.master bus
);
  localparam logic [3:0] c_cmd_active = 4'b0011;
  localparam logic [3:0] c_cmd_write  = 4'b0100;
  localparam logic [3:0] c_cmd_prech  = 4'b0010;
  localparam logic [3:0] c_cmd_nop    = 4'b0111;

  localparam logic [4:0] S_IDLE  = 5'b00001;
  localparam logic [4:0] S_REQ   = 5'b00010;
  localparam logic [4:0] S_ACT   = 5'b00100;
  localparam logic [4:0] S_WRITE = 5'b01000;
  localparam logic [4:0] S_PRECH = 5'b10000;

  localparam int                   c_burst_w     = $clog2(BURST_TIMES + 1);
  localparam logic [c_burst_w-1:0] c_burst_times = c_burst_w'(BURST_TIMES);
  localparam logic [8:0]           c_col_last    = 9'(COL_ADDR_END - 4);
  localparam logic [12:0]          c_row_last    = 13'(ROW_ADDR_END - 1);
  localparam logic [1:0]           c_bank        = 2'(BANK);

  logic [4:0]           r_state, w_state_nxt;
  logic                 r_act_cnt, r_prech_cnt;
  logic [2:0]           r_write_cnt;
  logic [c_burst_w-1:0] r_burst_cnt;
  logic [8:0]           r_col_addr;
  logic [12:0]          r_row_addr;
  logic                 r_write_end, r_write_req, r_prech_end;
  logic [3:0]           r_cmd, w_cmd_nxt;
  logic [12:0]          r_addr, w_addr_nxt;
  logic [15:0]          r_dq;
  logic                 r_dq_oe;
  logic                 w_row_last, w_burst_done, w_wr_req;

  assign w_row_last   = (r_col_addr == c_col_last);
  assign w_burst_done = (r_state == S_WRITE) && (r_write_cnt == 3'd5);
  assign w_wr_req     = (r_state == S_WRITE) && (r_write_cnt <= 3'd3);

  always_ff @(posedge sysclk_100M or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (bus.write_trig) w_state_nxt = S_REQ;
      S_REQ:   if (bus.arbit_write_ack) w_state_nxt = S_ACT;
      S_ACT:   if (r_act_cnt) w_state_nxt = S_WRITE;
      S_WRITE: if (w_burst_done && (r_write_end || bus.refresh_req || w_row_last))
                 w_state_nxt = S_PRECH;
      S_PRECH: if (r_prech_cnt) begin
                 if (r_write_end)          w_state_nxt = S_IDLE;
                 else if (bus.refresh_req) w_state_nxt = S_REQ;
                 else                      w_state_nxt = S_ACT;
               end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Command decode; the address bus holds its last value across NOPs.
  always_comb begin
    w_cmd_nxt  = c_cmd_nop;
    w_addr_nxt = r_addr;
    case (r_state)
      S_ACT: if (!r_act_cnt) begin
        w_cmd_nxt  = c_cmd_active;
        w_addr_nxt = r_row_addr;
      end
      S_WRITE: if (r_write_cnt == 3'd0) begin
        w_cmd_nxt  = c_cmd_write;
        w_addr_nxt = {4'b0000, r_col_addr};
      end
      S_PRECH: if (!r_prech_cnt) begin
        w_cmd_nxt  = c_cmd_prech;
        w_addr_nxt = 13'h400;
      end
      default: ;
    endcase
  end

  always_ff @(posedge sysclk_100M or negedge rst_n) begin
    if (!rst_n) begin
      r_act_cnt   <= 1'b0;
      r_prech_cnt <= 1'b0;
      r_write_cnt <= 3'd0;
    end else begin
      r_act_cnt   <= (r_state == S_ACT)   ? ~r_act_cnt   : 1'b0;
      r_prech_cnt <= (r_state == S_PRECH) ? ~r_prech_cnt : 1'b0;
      if (r_state == S_WRITE) r_write_cnt <= w_burst_done ? 3'd0 : r_write_cnt + 3'd1;
      else                    r_write_cnt <= 3'd0;
    end
  end

  always_ff @(posedge sysclk_100M or negedge rst_n) begin
    if (!rst_n) begin
      r_burst_cnt <= '0;
      r_write_end <= 1'b0;
    end else begin
      if (r_state == S_WRITE && r_write_cnt == 3'd3)
        r_burst_cnt <= r_burst_cnt + 1'b1;
      else if (r_state == S_WRITE && r_write_cnt == 3'd4 && r_burst_cnt == c_burst_times)
        r_burst_cnt <= '0;

      if (r_state != S_ACT && w_state_nxt == S_ACT)
        r_write_end <= 1'b0;
      else if (r_state == S_WRITE && r_write_cnt == 3'd4 && r_burst_cnt == c_burst_times)
        r_write_end <= 1'b1;
    end
  end

  // Linear walk: column steps per burst, row steps on the last column, region wraps.
  always_ff @(posedge sysclk_100M or negedge rst_n) begin
    if (!rst_n) begin
      r_col_addr <= 9'd0;
      r_row_addr <= 13'd0;
    end else if (w_burst_done) begin
      if (w_row_last) begin
        r_col_addr <= 9'd0;
        r_row_addr <= (r_row_addr == c_row_last) ? 13'd0 : r_row_addr + 13'd1;
      end else begin
        r_col_addr <= r_col_addr + 9'd4;
      end
    end
  end

  always_ff @(posedge sysclk_100M or negedge rst_n) begin
    if (!rst_n) begin
      r_cmd       <= c_cmd_nop;
      r_addr      <= 13'h400;
      r_dq        <= 16'd0;
      r_dq_oe     <= 1'b0;
      r_write_req <= 1'b0;
      r_prech_end <= 1'b0;
    end else begin
      r_cmd       <= w_cmd_nxt;
      r_addr      <= w_addr_nxt;
      r_dq_oe     <= w_wr_req;
      if (w_wr_req) r_dq <= bus.wr_data;
      r_write_req <= (w_state_nxt == S_REQ);
      r_prech_end <= (r_state == S_PRECH) && r_prech_cnt;
    end
  end

`ifdef WRITE_PINGPONG_EN
  logic [1:0] r_bank;
  logic       w_region_wrap;
  assign w_region_wrap = w_burst_done && w_row_last && (r_row_addr == c_row_last);

  always_ff @(posedge sysclk_100M or negedge rst_n) begin
    if (!rst_n)             r_bank <= c_bank;
    else if (w_region_wrap) r_bank <= r_bank ^ 2'b10;
  end
  assign bus.sdram_bank_addr = r_bank;
`else
  assign bus.sdram_bank_addr = c_bank;
`endif

  assign bus.arbit_write_req = r_write_req;
  assign bus.arbit_write_end = r_write_end;
  assign bus.arbit_prech_end = r_prech_end;
  assign bus.cmd_reg         = r_cmd;
  assign bus.sdram_addr      = r_addr;
  assign bus.wr_data_req     = w_wr_req;
  assign bus.sdram_dq        = r_dq;
  assign bus.sdram_dq_oe     = r_dq_oe;
endmodule
`default_nettype wire
